// File: rtl/aes_pkg.sv
// AES-256 shared definitions: sizes, FSM state encoding, S-box and Rcon tables,
// and the GF(2^8) helpers used by the round and key-expansion logic.
package aes_pkg;

    localparam int unsigned NR    = 14;   // rounds for AES-256
    localparam int unsigned BLK_W = 128;  // data block width
    localparam int unsigned KEY_W = 256;  // cipher key width
    localparam int unsigned RND_W = 4;    // round counter width

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } aes_state_e;

    // FIPS-197 forward S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constants Rcon[1..7]; entry 0 here is Rcon[1].
    localparam logic [7:0] RCON [7] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Rcon lookup that yields zero past the end of the table.
    function automatic logic [7:0] rcon_lookup(input logic [2:0] idx);
        return (idx < 3'd7) ? RCON[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box substitution of one byte (pure combinational lookup).
// Ports: plain - byte to substitute; subst - substituted byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] plain,
    output logic [7:0] subst
);

    assign subst = SBOX[plain];

endmodule

// File: rtl/cipher.sv
// Iterative AES-256 encryptor: one full round per clock, round keys expanded
// on the fly from a two-register sliding window.
// Ports: clk_i/rst_i clock and async active-high reset; ready_i start request
// (sampled in IDLE); plain_text_i/cipher_key_i captured on start; done_o one-
// cycle completion pulse; cipher_text_o registered result held until the next.
module cipher
    import aes_pkg::*;
#(
    parameter int unsigned NR = aes_pkg::NR
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ready_i,
    input  logic [BLK_W-1:0] plain_text_i,
    input  logic [KEY_W-1:0] cipher_key_i,
    output logic             done_o,
    output logic [BLK_W-1:0] cipher_text_o
);

    aes_state_e       state_q, state_d;
    logic [RND_W-1:0] round_q;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] key_a_q;   // round key r-1
    logic [BLK_W-1:0] key_b_q;   // round key r (used by the current round)
    logic [BLK_W-1:0] ct_q;
    logic             done_q;

    logic             load_c;
    logic             step_c;
    logic             last_c;

    logic [7:0]       sub_b [16];
    logic [7:0]       sr_b  [16];
    logic [7:0]       mc_b  [16];
    logic [BLK_W-1:0] rnd_c;

    logic [31:0]      sw_c;
    logic [31:0]      kx_word_c;
    logic [7:0]       rcon_c;
    logic [BLK_W-1:0] nk_c;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ready_i) state_d = ROUND;
            ROUND:   if (last_c)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        load_c = 1'b0;
        step_c = 1'b0;
        last_c = 1'b0;
        unique case (state_q)
            IDLE: load_c = ready_i;
            ROUND: begin
                step_c = 1'b1;
                last_c = (round_q == RND_W'(NR));
            end
            default: ;
        endcase
    end

    // SubBytes on the 16 state bytes
    for (genvar k = 0; k < 16; k++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .plain (blk_q[BLK_W-1-8*k -: 8]),
            .subst (sub_b[k])
        );
    end

    // SubWord on the last word of the current round key
    for (genvar k = 0; k < 4; k++) begin : g_sub_word
        aes_sbox u_sbox (
            .plain (key_b_q[31-8*k -: 8]),
            .subst (sw_c[31-8*k -: 8])
        );
    end

    // ShiftRows: byte (row r, column c) sits at index r + 4c; row r rotates left by r
    always_comb begin
        sr_b = '{default: 8'h00};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_b[r + 4*c] = sub_b[r + 4*((c + r) % 4)];
            end
        end
    end

    // MixColumns: out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3)
    always_comb begin
        mc_b = '{default: 8'h00};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mc_b[4*c + r] = xtime(sr_b[4*c + r])
                              ^ xtime(sr_b[4*c + (r + 1) % 4]) ^ sr_b[4*c + (r + 1) % 4]
                              ^ sr_b[4*c + (r + 2) % 4]
                              ^ sr_b[4*c + (r + 3) % 4];
            end
        end
    end

    // AddRoundKey; the final round bypasses MixColumns
    always_comb begin
        rnd_c = '0;
        for (int k = 0; k < 16; k++) begin
            rnd_c[BLK_W-1-8*k -: 8] = (last_c ? sr_b[k] : mc_b[k]) ^ key_b_q[BLK_W-1-8*k -: 8];
        end
    end

    // Next round key r+1 from keys r-1 and r. Its first word index is 4(r+1),
    // which is a multiple of 8 exactly when r is odd; Rcon index is then (r+1)/2.
    always_comb begin
        rcon_c    = rcon_lookup(round_q[3:1]);
        kx_word_c = sw_c;
        if (round_q[0]) begin
            kx_word_c = {sw_c[23:0], sw_c[31:24]} ^ {rcon_c, 24'h000000};
        end
        nk_c[127:96] = key_a_q[127:96] ^ kx_word_c;
        nk_c[95:64]  = key_a_q[95:64]  ^ nk_c[127:96];
        nk_c[63:32]  = key_a_q[63:32]  ^ nk_c[95:64];
        nk_c[31:0]   = key_a_q[31:0]   ^ nk_c[63:32];
    end

    // Datapath registers: capture, iterate, and publish the result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            round_q <= '0;
            blk_q   <= '0;
            key_a_q <= '0;
            key_b_q <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_c) begin
                blk_q   <= plain_text_i ^ cipher_key_i[KEY_W-1 -: BLK_W];
                key_a_q <= cipher_key_i[KEY_W-1 -: BLK_W];
                key_b_q <= cipher_key_i[BLK_W-1:0];
                round_q <= RND_W'(1);
            end else if (step_c) begin
                blk_q   <= rnd_c;
                key_a_q <= key_b_q;
                key_b_q <= nk_c;
                if (last_c) begin
                    ct_q    <= rnd_c;
                    done_q  <= 1'b1;
                    round_q <= '0;
                end else begin
                    round_q <= round_q + RND_W'(1);
                end
            end
        end
    end

    assign done_o        = done_q;
    assign cipher_text_o = ct_q;

endmodule

// File: tb/tb_cipher.sv
// Scoreboard bench for the AES-256 cipher with an independent software model.
module tb_cipher;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         ready_i;
    logic [127:0] plain_text_i;
    logic [255:0] cipher_key_i;
    logic         done_o;
    logic [127:0] cipher_text_o;

    cipher #(.NR(14)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ready_i       (ready_i),
        .plain_text_i  (plain_text_i),
        .cipher_key_i  (cipher_key_i),
        .done_o        (done_o),
        .cipher_text_o (cipher_text_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [127:0] ct;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CZ  = 128'hdc95c078a2408989ad48a21492842087;

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        logic [15:0] s = d >> (8 - n);
        return s[7:0];
    endfunction

    // S-box from multiplicative inverse plus affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [127:0] res = '0;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
        for (int r = 0; r <= 14; r++) begin
            if (r > 0) begin
                for (int k = 0; k < 16; k++) s[k] = sbox_m[s[k]];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++)
                        t[row + 4*c] = s[row + 4*((c + row) % 4)];
                s = t;
                if (r < 14) begin
                    for (int c = 0; c < 4; c++)
                        for (int row = 0; row < 4; row++)
                            t[4*c + row] = gmul(s[4*c + row], 8'h02)
                                         ^ gmul(s[4*c + (row + 1) % 4], 8'h03)
                                         ^ s[4*c + (row + 2) % 4]
                                         ^ s[4*c + (row + 3) % 4];
                    s = t;
                end
            end
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[4*c + j] = s[4*c + j] ^ w[4*r + c][31-8*j -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand128(), rand128()};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done_o=1 at cycle %0d ct=%h, required no completion", cyc, cipher_text_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (cipher_text_o !== mon_e.ct || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL result: got ct=%h at cycle %0d, required ct=%h at cycle %0d",
                                 cipher_text_o, cyc, mon_e.ct, mon_e.due);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_block(input logic [127:0] pt, input logic [255:0] key,
                               input bit push, input logic [127:0] exp_ct);
        @(negedge clk_i);
        plain_text_i = pt;
        cipher_key_i = key;
        ready_i      = 1'b1;
        @(posedge clk_i);
        #1;
        if (push) sb_q.push_back('{ct: exp_ct, due: cyc + 14});
        ready_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && sb_q.size() != 0; i++) @(negedge clk_i);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_out(input string name, input logic exp_done, input logic [127:0] exp_ct);
        checks++;
        if (done_o !== exp_done || cipher_text_o !== exp_ct) begin
            errors++;
            $display("FAIL %s: done_o=%b ct=%h, required done_o=%b ct=%h",
                     name, done_o, cipher_text_o, exp_done, exp_ct);
        end
    endtask

    initial begin
        logic [127:0] pt;
        logic [255:0] key;
        rst_i        = 1'b1;
        ready_i      = 1'b0;
        plain_text_i = '0;
        cipher_key_i = '0;
        build_sbox();

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_out("reset_state", 1'b0, '0);
        rst_i = 1'b0;

        // idle with ready low: nothing moves
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            plain_text_i = rand128();
            cipher_key_i = rand256();
            check_out("idle_hold", 1'b0, '0);
        end

        // known-answer vectors
        start_block(P1, K1, 1'b1, C1);
        wait_drain();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            plain_text_i = rand128();
            cipher_key_i = rand256();
        end
        check_out("result_hold", 1'b0, C1);

        start_block('0, '0, 1'b1, CZ);
        wait_drain();

        // inputs changed mid-operation are ignored
        start_block(P1, K1, 1'b1, C1);
        repeat (3) @(negedge clk_i);
        plain_text_i = rand128();
        cipher_key_i = rand256();
        wait_drain();

        // reset during round 7 aborts; restart gives the known answer
        start_block(P1, K1, 1'b0, '0);
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_out("abort_reset", 1'b0, '0);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check_out("abort_quiet", 1'b0, '0);
        start_block(P1, K1, 1'b1, C1);
        wait_drain();

        // random blocks with random gaps
        for (int n = 0; n < 8; n++) begin
            pt  = rand128();
            key = rand256();
            start_block(pt, key, 1'b1, aes_ref(pt, key));
            wait_drain();
            repeat ($urandom_range(0, 5)) @(negedge clk_i);
        end

        // ready held high: one result every 15 cycles, garbage inputs in between
        @(negedge clk_i);
        for (int n = 0; n < 4; n++) begin
            pt  = rand128();
            key = rand256();
            plain_text_i = pt;
            cipher_key_i = key;
            ready_i      = 1'b1;
            @(posedge clk_i);
            #1;
            sb_q.push_back('{ct: aes_ref(pt, key), due: cyc + 14});
            for (int j = 0; j < 14; j++) begin
                @(negedge clk_i);
                plain_text_i = rand128();
                cipher_key_i = rand256();
                @(posedge clk_i);
            end
            @(negedge clk_i);
        end
        ready_i = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cipher.md
CIPHER -- requirements
Module: cipher

Interface
REQ-001 SHALL have parameter NR, default 14, meaning number of AES rounds; only 14 (AES-256) is supported.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port ready_i, input, 1 bit: start request, sampled only while idle.
REQ-005 SHALL have port plain_text_i, input, 128 bits: plaintext block, byte 0 in bits [127:120].
REQ-006 SHALL have port cipher_key_i, input, 256 bits: AES-256 key, byte 0 in bits [255:248].
REQ-007 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port cipher_text_o, output, 128 bits: ciphertext, same byte order as plain_text_i; registered.

Function
REQ-009 SHALL implement FIPS-197 AES-256 encryption only; no decryption.
REQ-010 SHALL use an FSM with states IDLE and ROUND, plus a 4-bit round counter.
REQ-011 IDLE with ready_i=1 at an edge (capture edge C):
- load state = plain_text_i XOR cipher_key_i[255:128];
- load the key registers from cipher_key_i;
- set round counter = 1 and go to ROUND.
REQ-012 IDLE with ready_i=0 SHALL hold all registers.
REQ-013 ROUND SHALL perform one full round per clock, iterative, in the order SubBytes, ShiftRows, MixColumns, AddRoundKey.
REQ-014 Round 14 SHALL omit MixColumns.
REQ-015 Round r SHALL use round key r (words w[4r..4r+3]); round 1 uses cipher_key_i[127:0].
REQ-016 Round keys SHALL be generated on the fly from two 128-bit key registers, one new round key per cycle.
REQ-017 New round key r, for r >= 2:
- first word of the key two steps back, XOR transform(last word of the previous key);
- remaining words are a chained XOR.
REQ-018 transform for key-expansion word index i SHALL be:
- i mod 8 = 0: SubWord(RotWord) XOR Rcon[i/8];
- i mod 8 = 4: SubWord only.
Rcon = 01,02,04,08,10,20,40.
REQ-019 At the edge completing round 14 the block SHALL:
- load cipher_text_o with the result;
- set done_o=1 for exactly one cycle;
- return to IDLE.
REQ-020 Latency SHALL be: done_o high in the cycle after edge C+14; back-to-back starts with ready_i held 1 give one result per 15 cycles.
REQ-021 cipher_text_o SHALL hold its value until the next completion.
REQ-022 ready_i, plain_text_i and cipher_key_i SHALL be ignored outside the capture edge; changing them mid-operation has no effect.
REQ-023 Arithmetic SHALL use GF(2^8) with polynomial 0x11B; xtime = shift left, XOR 0x1B on carry.

Reset
REQ-024 rst_i=1 SHALL immediately force:
- FSM to IDLE, round counter 0;
- done_o=0, cipher_text_o=0;
- state and key registers to 0.
REQ-025 Reset asserted mid-operation SHALL abort the block with no done_o pulse.
REQ-026 After reset releases, the first capture SHALL occur at the first edge with ready_i=1.

Structure
REQ-027 Package aes_pkg SHALL hold the S-box table, the Rcon table, the NR constant and the FSM state enum.
REQ-028 SHALL use one combinational sub-module, aes_sbox (8-bit in, 8-bit out).
REQ-029 aes_sbox SHALL be instantiated 16 times for SubBytes and 4 times for SubWord.
REQ-030 ShiftRows, MixColumns and key expansion SHALL be combinational logic inside cipher.

Verification
REQ-031 Key 000102...1e1f, plaintext 00112233445566778899aabbccddeeff, ready_i=1 -> done_o pulse at C+14, cipher_text_o = 8ea2b7ca516745bfeafc49904b496089.
REQ-032 All-zero key and all-zero plaintext -> cipher_text_o = dc95c078a2408989ad48a21492842087.
REQ-033 ready_i held 0 for 50 cycles after reset -> done_o stays 0 and cipher_text_o stays 0.
REQ-034 rst_i pulsed during round 7 -> no done_o and outputs 0; a new start afterwards gives the REQ-031 result.
REQ-035 plain_text_i and cipher_key_i changed to random values at C+3 -> result still matches REQ-031.
REQ-036 ready_i held 1 continuously -> done_o pulses every 15 cycles with the correct result each time.
